sdram_arbiter_n: RTL and testbench

SDRAM_ARBITER_N -- requirements
Module: sdram_arbiter_n

---
 rtl/sdram_arbiter_n.sv | 175 +++++++++++++++++
 tb/tb_sdram_arbiter_n.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_n.sv
`default_nettype none
// =============================================================================
// Module      : sdram_arbiter_n
// Description : N-client arbiter in front of a single-outstanding SDRAM bridge;
//               fixed high-priority clients, then fixed or round-robin order.
// Revision    : 1.0 - initial release
// =============================================================================
module sdram_arbiter_n #(
    parameter int                     N_CLIENTS  = 8,
    parameter int                     ADDR_W     = 22,
    parameter int                     DATA_W     = 128,
    parameter int                     BE_W       = DATA_W / 8,
    parameter logic [N_CLIENTS-1:0]   HIPRI_MASK = 8'b0000_0011,
    parameter int                     RR_MODE    = 1,
    parameter int                     TIMEOUT    = 1023
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_CLIENTS-1:0]            cl_rd,
    input  logic [N_CLIENTS-1:0]            cl_wr,
    input  logic [N_CLIENTS*ADDR_W-1:0]     cl_addr,
    input  logic [N_CLIENTS*DATA_W-1:0]     cl_wrdata,
    input  logic [N_CLIENTS*BE_W-1:0]       cl_be,
    output logic [N_CLIENTS-1:0]            cl_wait,
    output logic [N_CLIENTS-1:0]            cl_ac,
    output logic [DATA_W-1:0]               cl_rddata,
    output logic [ADDR_W-1:0]               br_address,
    output logic                            br_read,
    output logic                            br_write,
    output logic [DATA_W-1:0]               br_wrdata,
    output logic [BE_W-1:0]                 br_be,
    input  logic                            br_ac,
    input  logic [DATA_W-1:0]               br_rddata,
    output logic [$clog2(N_CLIENTS)-1:0]    grant_id,
    output logic                            busy,
    output logic                            timeout_err,
    output logic                            proto_err
);

    localparam int c_id_w  = $clog2(N_CLIENTS);
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_id_w:0]    c_n_clients = (c_id_w + 1)'(N_CLIENTS);
    localparam logic [c_cnt_w-1:0] c_tmo_last  = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_id_w-1:0]      r_grant;
    logic [c_id_w-1:0]      r_rr_ptr;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wrdata;
    logic [BE_W-1:0]        r_be;
    logic                   r_br_read;
    logic                   r_br_write;
    logic [N_CLIENTS-1:0]   r_cl_ac;
    logic [DATA_W-1:0]      r_cl_rddata;
    logic                   r_timeout_err;
    logic                   r_proto_err;

    logic [N_CLIENTS-1:0]   w_req;
    logic [N_CLIENTS-1:0]   w_hi_req;
    logic [N_CLIENTS-1:0]   w_lo_req;
    logic                   w_hi_any;
    logic [c_id_w:0]        w_shamt;
    logic [N_CLIENTS-1:0]   w_rot;
    logic [c_id_w:0]        w_rr_sum;
    logic [c_id_w-1:0]      w_rr_win;
    logic [c_id_w-1:0]      w_win;
    logic [N_CLIENTS-1:0]   w_ac_mask;

    function automatic logic [c_id_w-1:0] f_lowest(input logic [N_CLIENTS-1:0] v);
        f_lowest = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (v[i]) f_lowest = c_id_w'(i);
        end
    endfunction

    assign w_req    = cl_rd | cl_wr;
    assign w_hi_req = w_req & HIPRI_MASK;
    assign w_lo_req = w_req & ~HIPRI_MASK;
    assign w_hi_any = |w_hi_req;

    // Rotate normal requests so bit 0 is the client just after rr_ptr; the
    // lowest set bit is then the round-robin offset from that point.
    assign w_shamt  = {1'b0, r_rr_ptr} + (c_id_w + 1)'(1);
    assign w_rot    = N_CLIENTS'({w_lo_req, w_lo_req} >> w_shamt);
    assign w_rr_sum = w_shamt + {1'b0, f_lowest(w_rot)};
    assign w_rr_win = (w_rr_sum >= c_n_clients) ? c_id_w'(w_rr_sum - c_n_clients)
                                                : w_rr_sum[c_id_w-1:0];

    assign w_win = w_hi_any      ? f_lowest(w_hi_req) :
                   (RR_MODE == 0) ? f_lowest(w_lo_req) : w_rr_win;

    assign w_ac_mask = {{(N_CLIENTS-1){1'b0}}, 1'b1} << r_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_rr_ptr      <= c_id_w'(N_CLIENTS - 1);
            r_cnt         <= '0;
            r_addr        <= '0;
            r_wrdata      <= '0;
            r_be          <= '0;
            r_br_read     <= 1'b0;
            r_br_write    <= 1'b0;
            r_cl_ac       <= '0;
            r_cl_rddata   <= '0;
            r_timeout_err <= 1'b0;
            r_proto_err   <= 1'b0;
        end else begin
            r_cl_ac <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_state    <= S_ISSUE;
                        r_grant    <= w_win;
                        r_addr     <= cl_addr[int'(w_win)*ADDR_W +: ADDR_W];
                        r_wrdata   <= cl_wrdata[int'(w_win)*DATA_W +: DATA_W];
                        r_be       <= cl_be[int'(w_win)*BE_W +: BE_W];
                        // Write takes precedence when a client raises both strobes.
                        r_br_write <= cl_wr[w_win];
                        r_br_read  <= ~cl_wr[w_win];
                        r_cnt      <= '0;
                        if (cl_rd[w_win] & cl_wr[w_win]) r_proto_err <= 1'b1;
                        if (!w_hi_any) r_rr_ptr <= w_win;
                    end
                end
                S_ISSUE: begin
                    if (br_ac) begin
                        if (r_br_read) r_cl_rddata <= br_rddata;
                        r_br_read  <= 1'b0;
                        r_br_write <= 1'b0;
                        r_cl_ac    <= w_ac_mask;
                        r_state    <= S_DONE;
                    end else if (r_cnt == c_tmo_last) begin
                        r_br_read     <= 1'b0;
                        r_br_write    <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_cl_ac       <= w_ac_mask;
                        r_state       <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cl_wait     = w_req & ~r_cl_ac;
    assign cl_ac       = r_cl_ac;
    assign cl_rddata   = r_cl_rddata;
    assign br_address  = r_addr;
    assign br_read     = r_br_read;
    assign br_write    = r_br_write;
    assign br_wrdata   = r_wrdata;
    assign br_be       = r_be;
    assign grant_id    = r_grant;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_timeout_err;
    assign proto_err   = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter_n.sv
`default_nettype none
// =============================================================================
// Module      : tb_sdram_arbiter_n
// Description : Self-checking bench for sdram_arbiter_n (table, directed and
//               random transactions against a transaction-level model).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_sdram_arbiter_n;

    localparam int N   = 8;
    localparam int AW  = 22;
    localparam int DW  = 128;
    localparam int BW  = 16;
    localparam int TMO = 8;
    localparam logic [7:0] HIPRI = 8'b0000_0011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] rd = '0;
    logic [7:0] wr = '0;
    logic [AW-1:0] addr_a [N];
    logic [DW-1:0] data_a [N];
    logic [BW-1:0] be_a   [N];
    logic [N*AW-1:0] cl_addr;
    logic [N*DW-1:0] cl_wrdata;
    logic [N*BW-1:0] cl_be;
    logic [DW-1:0]   br_rd = '0;
    logic man_ack = 1'b0;
    logic auto_a  = 1'b0;

    logic [7:0] cl_wait_a, cl_ac_a, cl_wait_b, cl_ac_b;
    logic [DW-1:0] cl_rddata_a, br_wrdata_a, cl_rddata_b, br_wrdata_b;
    logic [AW-1:0] br_address_a, br_address_b;
    logic [BW-1:0] br_be_a, br_be_b;
    logic [2:0] grant_id_a, grant_id_b;
    logic br_read_a, br_write_a, busy_a, timeout_err_a, proto_err_a, br_ac_a;
    logic br_read_b, br_write_b, busy_b, timeout_err_b, proto_err_b, br_ac_b;

    int n_vec = 0;
    int n_bad = 0;

    int m_rr;
    bit m_tmo, m_proto;
    logic [DW-1:0] m_rddata;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign cl_addr[g*AW +: AW]   = addr_a[g];
        assign cl_wrdata[g*DW +: DW] = data_a[g];
        assign cl_be[g*BW +: BW]     = be_a[g];
    end

    assign br_ac_a = auto_a ? (br_read_a | br_write_a) : man_ack;
    assign br_ac_b = br_read_b | br_write_b;

    always #5 clk = ~clk;

    sdram_arbiter_n #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW),
                      .HIPRI_MASK(HIPRI), .RR_MODE(1), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .reset(reset), .cl_rd(rd), .cl_wr(wr), .cl_addr(cl_addr),
        .cl_wrdata(cl_wrdata), .cl_be(cl_be), .cl_wait(cl_wait_a), .cl_ac(cl_ac_a),
        .cl_rddata(cl_rddata_a), .br_address(br_address_a), .br_read(br_read_a),
        .br_write(br_write_a), .br_wrdata(br_wrdata_a), .br_be(br_be_a),
        .br_ac(br_ac_a), .br_rddata(br_rd), .grant_id(grant_id_a), .busy(busy_a),
        .timeout_err(timeout_err_a), .proto_err(proto_err_a));

    sdram_arbiter_n #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW),
                      .HIPRI_MASK(HIPRI), .RR_MODE(0), .TIMEOUT(TMO)) dut_b (
        .clk(clk), .reset(reset), .cl_rd(rd), .cl_wr(wr), .cl_addr(cl_addr),
        .cl_wrdata(cl_wrdata), .cl_be(cl_be), .cl_wait(cl_wait_b), .cl_ac(cl_ac_b),
        .cl_rddata(cl_rddata_b), .br_address(br_address_b), .br_read(br_read_b),
        .br_write(br_write_b), .br_wrdata(br_wrdata_b), .br_be(br_be_b),
        .br_ac(br_ac_b), .br_rddata(br_rd), .grant_id(grant_id_b), .busy(busy_b),
        .timeout_err(timeout_err_b), .proto_err(proto_err_b));

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Arbitration rule: lowest HIPRI requester, else first normal requester
    // after the last normal winner, going round the client list.
    function automatic int model_pick(input logic [7:0] req);
        int c;
        for (int i = 0; i < N; i++) if (req[i] && HIPRI[i]) return i;
        for (int k = 1; k <= N; k++) begin
            c = (m_rr + k) % N;
            if (req[c] && !HIPRI[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rd = '0; wr = '0; man_ack = 1'b0; auto_a = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_rr = N - 1; m_tmo = 0; m_proto = 0; m_rddata = '0;
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < N; i++) begin
            addr_a[i] = AW'($urandom);
            data_a[i] = {$urandom, $urandom, $urandom, $urandom};
            be_a[i]   = BW'($urandom);
        end
    endtask

    // Called at a negedge while dut_a is IDLE with requests already applied;
    // ack_at = strobe cycle carrying br_ac (0 = never, forcing a timeout).
    task automatic txn(input int id, input bit exp_wr, input int ack_at,
                       input logic [DW-1:0] rdat, input bit drop, input bit spur);
        bit acked;
        logic [7:0] onehot;
        acked  = 1'b0;
        onehot = 8'(1) << id;
        if (rd[id] && wr[id]) m_proto = 1'b1;
        if (!HIPRI[id]) m_rr = id;
        @(negedge clk);
        chk("grant_id", grant_id_a, id);
        chk("br_write", br_write_a, exp_wr);
        chk("br_read", br_read_a, !exp_wr);
        chk("br_address", br_address_a, addr_a[id]);
        chk("br_wrdata", br_wrdata_a, data_a[id]);
        chk("br_be", br_be_a, be_a[id]);
        chk("busy_issue", busy_a, 1'b1);
        chk("cl_wait_issue", cl_wait_a, rd | wr);
        for (int k = 1; k <= TMO; k++) begin
            if (k > 1) chk("strobe_hold", exp_wr ? br_write_a : br_read_a, 1'b1);
            if (k == ack_at) begin man_ack = 1'b1; br_rd = rdat; end
            if (drop && k == 1) begin rd[id] = 1'b0; wr[id] = 1'b0; end
            @(negedge clk);
            man_ack = 1'b0;
            if (k == ack_at) begin acked = 1'b1; break; end
        end
        if (acked && !exp_wr) m_rddata = rdat;
        if (!acked) m_tmo = 1'b1;
        chk("cl_ac", cl_ac_a, onehot);
        chk("strobes_done", {br_read_a, br_write_a}, 2'b00);
        chk("cl_rddata", cl_rddata_a, m_rddata);
        chk("timeout_err", timeout_err_a, m_tmo);
        chk("proto_err", proto_err_a, m_proto);
        chk("cl_wait_done", cl_wait_a, (rd | wr) & ~onehot);
        rd[id] = 1'b0; wr[id] = 1'b0;
        if (spur) man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        chk("cl_ac_clear", cl_ac_a, 8'h00);
        chk("busy_idle", busy_a, 1'b0);
    endtask

    typedef struct {
        logic [7:0] rd;
        logic [7:0] wr;
        int         id;
        bit         is_wr;
    } vec_t;

    vec_t tbl [10];
    int qa [$];
    int qb [$];
    int exp_rr [6];
    int w, a;
    logic [DW-1:0] rdat;
    logic [DW-1:0] data_pat;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hA0, 8'h00, 5, 1'b0};
        tbl[1] = '{8'hA0, 8'h00, 7, 1'b0};
        tbl[2] = '{8'h04, 8'h08, 2, 1'b0};
        tbl[3] = '{8'h04, 8'h08, 3, 1'b1};
        tbl[4] = '{8'h42, 8'h00, 1, 1'b0};
        tbl[5] = '{8'h40, 8'h00, 6, 1'b0};
        tbl[6] = '{8'h00, 8'h81, 0, 1'b1};
        tbl[7] = '{8'h0C, 8'h00, 2, 1'b0};
        tbl[8] = '{8'h00, 8'h18, 3, 1'b1};
        tbl[9] = '{8'h03, 8'h00, 0, 1'b0};
        randomize_fields();

        // Reset values
        do_reset();
        chk("rst_br_read", br_read_a, 1'b0);
        chk("rst_br_write", br_write_a, 1'b0);
        chk("rst_cl_ac", cl_ac_a, 8'h00);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_grant_id", grant_id_a, 3'd0);
        chk("rst_br_address", br_address_a, '0);
        chk("rst_br_wrdata", br_wrdata_a, '0);
        chk("rst_br_be", br_be_a, '0);
        chk("rst_cl_rddata", cl_rddata_a, '0);
        chk("rst_timeout_err", timeout_err_a, 1'b0);
        chk("rst_proto_err", proto_err_a, 1'b0);
        chk("rst_cl_wait", cl_wait_a, 8'h00);

        // Arbitration table
        for (int i = 0; i < 10; i++) begin
            randomize_fields();
            rd = tbl[i].rd; wr = tbl[i].wr;
            txn(tbl[i].id, tbl[i].is_wr, 1 + (i % 4), {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
            rd = '0; wr = '0;
        end

        // Single read, acked on the fourth strobe cycle
        addr_a[5] = 22'h00123;
        data_pat  = {16{8'hA5}};
        rd[5] = 1'b1;
        txn(5, 1'b0, 4, data_pat, 1'b0, 1'b0);

        // Timeout then recovery
        rd[4] = 1'b1;
        txn(4, 1'b0, 0, {4{32'hDEAD_BEEF}}, 1'b0, 1'b0);
        rd[2] = 1'b1;
        txn(2, 1'b0, 2, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);

        // Read+write on one client
        be_a[1] = 16'h00FF;
        rd[1] = 1'b1; wr[1] = 1'b1;
        txn(1, 1'b1, 1, '0, 1'b0, 1'b0);
        wr[6] = 1'b1;
        txn(6, 1'b1, 2, '0, 1'b0, 1'b0);

        // Reset while client 3 write is on the bus
        wr[3] = 1'b1;
        @(negedge clk);
        chk("pre_rst_write", br_write_a, 1'b1);
        chk("pre_rst_grant", grant_id_a, 3'd3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_strobes", {br_read_a, br_write_a}, 2'b00);
        chk("midrst_cl_ac", cl_ac_a, 8'h00);
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_grant", grant_id_a, 3'd0);
        chk("midrst_addr", br_address_a, '0);
        chk("midrst_wrdata", br_wrdata_a, '0);
        chk("midrst_be", br_be_a, '0);
        chk("midrst_rddata", cl_rddata_a, '0);
        chk("midrst_tmo", timeout_err_a, 1'b0);
        chk("midrst_proto", proto_err_a, 1'b0);
        reset = 1'b0;
        m_rr = N - 1; m_tmo = 0; m_proto = 0; m_rddata = '0;
        rd[0] = 1'b1;
        txn(0, 1'b0, 1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        txn(3, 1'b1, 1, '0, 1'b0, 1'b0);

        // HIPRI versus pending normal client; pointer moves only on client 6
        do_reset();
        rd[6] = 1'b1; rd[0] = 1'b1;
        txn(0, 1'b0, 1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        txn(6, 1'b0, 1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        rd[5] = 1'b1; rd[7] = 1'b1;
        txn(7, 1'b0, 1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        rd = '0;

        // Continuous requesters 2, 4, 7 with instant ack on both modes
        do_reset();
        auto_a = 1'b1;
        rd = 8'b1001_0100;
        for (int c = 0; c < 60 && (qa.size() < 6 || qb.size() < 6); c++) begin
            @(negedge clk);
            if (br_read_a) qa.push_back(int'(grant_id_a));
            if (br_read_b) qb.push_back(int'(grant_id_b));
        end
        rd = '0;
        auto_a = 1'b0;
        exp_rr = '{2, 4, 7, 2, 4, 7};
        for (int i = 0; i < 6; i++) begin
            chk("rr_order", (i < qa.size()) ? qa[i] : 99, exp_rr[i]);
            chk("fixed_order", (i < qb.size()) ? qb[i] : 99, 2);
        end

        // Randomized traffic against the model
        do_reset();
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                rd = '0; wr = '0;
            end else begin
                rd = 8'($urandom & $urandom);
                wr = 8'($urandom & $urandom & $urandom);
            end
            randomize_fields();
            if ((rd | wr) == 8'h00) begin
                @(negedge clk);
                chk("idle_busy", busy_a, 1'b0);
                chk("idle_strobe", {br_read_a, br_write_a}, 2'b00);
            end else begin
                w = model_pick(rd | wr);
                a = $urandom_range(1, 10);
                if (a > TMO) a = 0;
                rdat = {$urandom, $urandom, $urandom, $urandom};
                txn(w, wr[w], a, rdat, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
